// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_responder_pkg
//   Shared definitions for the memory responder: host command encodings,
//   responder FSM states and the fixed host address width.
// ---------------------------------------------------------------------------
package mem_responder_pkg;

  // Host command bus is always 8 address bits; each RAM uses the low bits.
  localparam int HOST_ADDR_W = 8;
  localparam int CMD_W       = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_INSTR = 2'b00,
    CMD_WR_DATA  = 2'b01,
    CMD_RD_DATA  = 2'b10,
    CMD_RUN      = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RDRESP = 2'b01,
    RUN    = 2'b10
  } state_e;

endpackage

// File: rtl/ram_1w1r.sv
// ---------------------------------------------------------------------------
// ram_1w1r
//   Simple RAM with one synchronous write port and one asynchronous
//   (combinational) read port. A read of the address being written returns
//   the old contents until the write edge has passed.
//
// Ports:
//   clk      clock for the write port
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, combinational from i_raddr
// ---------------------------------------------------------------------------
module ram_1w1r #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];

  // NOTE: the array has no reset on purpose: contents must survive a reset,
  // and a resettable array cannot map onto RAM macros. Sequential writes use
  // non-blocking assignment so the read port sees the old value this cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the accumulator processor. Serves instruction
//   fetches and data accesses from two on-chip RAMs, and gives a host port
//   for loading instructions/data, reading data back, and running the
//   processor for a bounded number of cycles. The processor is held in
//   reset (cpu_rst=1) whenever it is not running.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   instr_addr   processor fetch address      -> instr (combinational)
//   mem_wr       processor data write enable (honoured only while running)
//   mem_addr     processor data address
//   cpu_wdata    processor write data
//   cpu_rdata    data word at mem_addr while running
//   cpu_rst      registered processor reset, 1 = held
//   host_valid   host command valid
//   host_ready   high in IDLE; command accepted when valid & ready
//   host_cmd     00 WR_INSTR, 01 WR_DATA, 10 RD_DATA, 11 RUN
//   host_addr    target address (low bits used per RAM)
//   host_wdata   write data, or cycle count for RUN
//   host_rvalid  one-cycle pulse with read data
//   host_rdata   read-back data, held until the next read
//   run_done     one-cycle pulse when a RUN finishes
// ---------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int IADDR_W = 8,
  parameter int INSTR_W = 12,
  parameter int DADDR_W = 8,
  parameter int DATA_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  // processor instruction port
  input  logic [IADDR_W-1:0]     instr_addr,
  output logic [INSTR_W-1:0]     instr,
  // processor data port
  input  logic                   mem_wr,
  input  logic [DADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_rst,
  // host command port
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [CMD_W-1:0]       host_cmd,
  input  logic [HOST_ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0]      host_wdata,
  output logic                   host_rvalid,
  output logic [DATA_W-1:0]      host_rdata,
  output logic                   run_done
);

  // FSM state and registered outputs
  state_e              r_state;
  logic                r_cpu_rst;
  logic                r_host_rvalid;
  logic [DATA_W-1:0]   r_host_rdata;
  logic                r_run_done;
  logic [DATA_W-1:0]   r_run_cnt;
  logic [DADDR_W-1:0]  r_rd_addr;

  // Command decode and RAM port wiring
  cmd_e                w_cmd;
  logic                w_accept;
  logic                w_iram_we;
  logic                w_dram_we;
  logic [DADDR_W-1:0]  w_dram_waddr;
  logic [DATA_W-1:0]   w_dram_wdata;
  logic [DADDR_W-1:0]  w_dram_raddr;
  logic [DATA_W-1:0]   w_dram_rdata;

  assign w_cmd      = cmd_e'(host_cmd);
  assign host_ready = (r_state == IDLE);
  assign w_accept   = host_valid & host_ready;
  assign w_iram_we  = w_accept && (w_cmd == CMD_WR_INSTR);

  // ---------------------------------------------------------------------------
  // Instruction RAM: host writes, processor reads every cycle.
  // ---------------------------------------------------------------------------
  ram_1w1r #(
    .WIDTH  (INSTR_W),
    .ADDR_W (IADDR_W)
  ) u_iram (
    .clk     (clk),
    .i_we    (w_iram_we),
    .i_waddr (host_addr[IADDR_W-1:0]),
    .i_wdata (host_wdata[INSTR_W-1:0]),
    .i_raddr (instr_addr),
    .o_rdata (instr)
  );

  // ---------------------------------------------------------------------------
  // Data RAM write port: the processor owns it while running, the host owns
  // it in IDLE. The two never overlap because host commands are only
  // accepted in IDLE.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default at the top so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    w_dram_we    = 1'b0;
    w_dram_waddr = host_addr[DADDR_W-1:0];
    w_dram_wdata = host_wdata;
    if (r_state == RUN) begin
      w_dram_we    = mem_wr;
      w_dram_waddr = mem_addr;
      w_dram_wdata = cpu_wdata;
    end else if (w_accept && (w_cmd == CMD_WR_DATA)) begin
      w_dram_we    = 1'b1;
    end
  end

  // Read port follows the processor while running, otherwise the address
  // latched by the last host read.
  assign w_dram_raddr = (r_state == RUN) ? mem_addr : r_rd_addr;

  ram_1w1r #(
    .WIDTH  (DATA_W),
    .ADDR_W (DADDR_W)
  ) u_dram (
    .clk     (clk),
    .i_we    (w_dram_we),
    .i_waddr (w_dram_waddr),
    .i_wdata (w_dram_wdata),
    .i_raddr (w_dram_raddr),
    .o_rdata (w_dram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Responder FSM, run counter and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cpu_rst     <= 1'b1;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
      r_run_done    <= 1'b0;
      r_run_cnt     <= '0;
      r_rd_addr     <= '0;
    end else begin
      // Pulses default low; the branches below raise them for one cycle.
      r_host_rvalid <= 1'b0;
      r_run_done    <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cpu_rst <= 1'b1;
          if (w_accept) begin
            case (w_cmd)
              CMD_RD_DATA: begin
                r_rd_addr     <= host_addr[DADDR_W-1:0];
                r_host_rvalid <= 1'b1;
                r_state       <= RDRESP;
              end
              CMD_RUN: begin
                // A zero count is a no-op: the processor never leaves reset.
                if (host_wdata != '0) begin
                  r_run_cnt <= host_wdata;
                  r_cpu_rst <= 1'b0;
                  r_state   <= RUN;
                end
              end
              default: ;  // RAM writes are handled by the write-port logic
            endcase
          end
        end

        RDRESP: begin
          // The response word is live from the RAM during this cycle; keep
          // a copy so host_rdata holds after the pulse.
          r_host_rdata <= w_dram_rdata;
          r_state      <= IDLE;
        end

        RUN: begin
          r_run_cnt <= r_run_cnt - DATA_W'(1);
          // Leaving on count==1 gives exactly N low cycles of cpu_rst.
          if (r_run_cnt == DATA_W'(1)) begin
            r_cpu_rst  <= 1'b1;
            r_run_done <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_cpu_rst <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rst     = r_cpu_rst;
  assign cpu_rdata   = w_dram_rdata;
  assign host_rvalid = r_host_rvalid;
  assign run_done    = r_run_done;
  // During the response cycle the stored copy is not yet loaded, so pass the
  // RAM word straight through.
  assign host_rdata  = (r_state == RDRESP) ? w_dram_rdata : r_host_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder: a table of host transactions with
//   expected results, hand-written multi-cycle sequences (back-to-back reads,
//   processor writes during RUN, reset mid-RUN), and a randomized phase
//   checked against array models of both RAMs.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam logic [1:0] C_WR_INSTR = 2'b00;
  localparam logic [1:0] C_WR_DATA  = 2'b01;
  localparam logic [1:0] C_RD_DATA  = 2'b10;
  localparam logic [1:0] C_RUN      = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  instr_addr = '0;
  logic [11:0] instr;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_rst;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [1:0]  host_cmd = '0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        run_done;

  mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .instr_addr  (instr_addr),
    .instr       (instr),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_rst     (cpu_rst),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_cmd    (host_cmd),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .run_done    (run_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of both RAMs for the randomized phase.
  logic [31:0] dram_m [256];
  logic [11:0] iram_m [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one host command. Called in the low clock phase; returns at the
  // falling edge right after the accepting rising edge.
  task automatic send(input logic [1:0] cmd, input logic [7:0] addr, input logic [31:0] wdata);
    int guard = 0;
    while (host_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (host_ready !== 1'b1) check("ready_timeout", 32'(host_ready), 32'd1);
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_addr  = addr;
    host_wdata = wdata;
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] addr, input logic [31:0] exp);
    send(C_RD_DATA, addr, $urandom);
    check({name, "_rvalid"}, 32'(host_rvalid), 32'd1);
    check({name, "_ready_low"}, 32'(host_ready), 32'd0);
    check({name, "_rdata"}, host_rdata, exp);
    @(negedge clk);
    check({name, "_rvalid_drop"}, 32'(host_rvalid), 32'd0);
    check({name, "_rdata_hold"}, host_rdata, exp);
  endtask

  // Run for n cycles with the processor idle on the data port and measure
  // how long cpu_rst stays low.
  task automatic run_check(input string name, input logic [31:0] n, input int exp_low);
    int low = 0;
    int bad_ready = 0;
    int bad_done = 0;
    send(C_RUN, 8'h00, n);
    while (cpu_rst === 1'b0 && low < 2000) begin
      if (host_ready !== 1'b0) bad_ready++;
      if (run_done !== 1'b0) bad_done++;
      low++;
      @(negedge clk);
    end
    check({name, "_low_cycles"}, 32'(low), 32'(exp_low));
    check({name, "_ready_in_run"}, 32'(bad_ready), 32'd0);
    check({name, "_done_early"}, 32'(bad_done), 32'd0);
    check({name, "_run_done"}, 32'(run_done), (exp_low != 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({name, "_done_once"}, 32'(run_done), 32'd0);
    check({name, "_cpu_rst_held"}, 32'(cpu_rst), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // instr value, read data, or cpu_rst low-cycle count
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int low;
    int pulses;
    int back_to_back;
    logic prev_rv;

    vecs[0]  = '{C_WR_INSTR, 8'h05, 32'hFFFF_F9A3, 32'h0000_09A3};
    vecs[1]  = '{C_WR_INSTR, 8'hFF, 32'h1234_5ABC, 32'h0000_0ABC};
    vecs[2]  = '{C_WR_DATA,  8'h10, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{C_WR_DATA,  8'h00, 32'h0000_0001, 32'h0};
    vecs[4]  = '{C_RD_DATA,  8'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[5]  = '{C_RD_DATA,  8'h00, 32'h0,         32'h0000_0001};
    vecs[6]  = '{C_WR_DATA,  8'h10, 32'h55AA_55AA, 32'h0};
    vecs[7]  = '{C_RD_DATA,  8'h10, 32'h0,         32'h55AA_55AA};
    vecs[8]  = '{C_RUN,      8'h00, 32'd0,         32'd0};
    vecs[9]  = '{C_RUN,      8'h00, 32'd1,         32'd1};
    vecs[10] = '{C_RUN,      8'h00, 32'd5,         32'd5};

    // ---------------- reset state ----------------
    #1 rst = 1'b1;
    #1;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_rdata", host_rdata, 32'd0);
    check("rst_run_done", 32'(run_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cpu_rst", 32'(cpu_rst), 32'd1);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      case (vecs[i].cmd)
        C_WR_INSTR: begin
          send(C_WR_INSTR, vecs[i].addr, vecs[i].wdata);
          instr_addr = vecs[i].addr;
          #1;
          check($sformatf("vec%0d_instr", i), 32'(instr), vecs[i].exp);
        end
        C_WR_DATA: send(C_WR_DATA, vecs[i].addr, vecs[i].wdata);
        C_RD_DATA: read_check($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp);
        default:   run_check($sformatf("vec%0d_run", i), vecs[i].wdata, int'(vecs[i].exp));
      endcase
    end

    // ---------------- back-to-back reads: one per two cycles ----------------
    @(negedge clk);
    host_valid = 1'b1;
    host_cmd   = C_RD_DATA;
    host_addr  = 8'h10;
    pulses = 0;
    back_to_back = 0;
    prev_rv = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (host_rvalid === 1'b1) pulses++;
      if (host_rvalid === 1'b1 && prev_rv === 1'b1) back_to_back++;
      prev_rv = host_rvalid;
    end
    host_valid = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_spacing", 32'(back_to_back), 32'd0);
    check("b2b_rdata", host_rdata, 32'h55AA_55AA);
    @(negedge clk);

    // ---------------- processor writes during RUN ----------------
    send(C_WR_DATA, 8'h30, 32'd1);
    send(C_RUN, 8'h00, 32'd6);
    mem_wr    = 1'b1;
    mem_addr  = 8'h20;
    cpu_wdata = 32'hFFFF_FFF9;  // -7
    @(negedge clk);
    mem_wr = 1'b0;
    #1 check("cpu_wr_readback", cpu_rdata, 32'hFFFF_FFF9);
    @(negedge clk);
    mem_wr    = 1'b1;
    mem_addr  = 8'h30;
    cpu_wdata = 32'd2;
    #1 check("rdw_old_value", cpu_rdata, 32'd1);
    @(negedge clk);
    mem_wr = 1'b0;
    #1 check("rdw_new_value", cpu_rdata, 32'd2);
    low = 0;
    while (cpu_rst === 1'b0 && low < 100) begin
      low++;
      @(negedge clk);
    end
    check("cpu_wr_run_rest", 32'(low), 32'd3);
    check("cpu_wr_run_done", 32'(run_done), 32'd1);
    @(negedge clk);
    read_check("cpu_wr_host_rd20", 8'h20, 32'hFFFF_FFF9);
    read_check("cpu_wr_host_rd30", 8'h30, 32'd2);

    // ---------------- mem_wr outside RUN is ignored ----------------
    mem_wr    = 1'b1;
    mem_addr  = 8'h20;
    cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    read_check("idle_mem_wr", 8'h20, 32'hFFFF_FFF9);
    mem_wr = 1'b0;

    // ---------------- reset in the middle of a RUN ----------------
    send(C_RUN, 8'h00, 32'd100);
    repeat (19) @(negedge clk);
    check("midrun_running", 32'(cpu_rst), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrun_rst_ready", 32'(host_ready), 32'd1);
    check("midrun_rst_done", 32'(run_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_after_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrun_after_ready", 32'(host_ready), 32'd1);
    read_check("midrun_rd20", 8'h20, 32'hFFFF_FFF9);
    read_check("midrun_rd10", 8'h10, 32'h55AA_55AA);
    instr_addr = 8'h05;
    #1 check("midrun_iram", 32'(instr), 32'h0000_09A3);

    // ---------------- randomized phase against array model ----------------
    for (int a = 0; a < 16; a++) begin
      logic [31:0] d;
      d = $urandom;
      send(C_WR_DATA, 8'h80 + 8'(a), d);
      dram_m[8'h80 + a] = d;
      d = $urandom;
      send(C_WR_INSTR, 8'h80 + 8'(a), d);
      iram_m[8'h80 + a] = d[11:0];
    end

    for (int it = 0; it < 120; it++) begin
      int sel;
      logic [7:0]  a;
      logic [31:0] d;
      sel = $urandom_range(0, 9);
      a   = 8'h80 | 8'($urandom_range(0, 15));
      d   = $urandom;
      if (sel <= 2) begin
        send(C_WR_DATA, a, d);
        dram_m[a] = d;
      end else if (sel <= 4) begin
        logic [7:0] ra;
        send(C_WR_INSTR, a, d);
        iram_m[a] = d[11:0];
        ra = 8'h80 | 8'($urandom_range(0, 15));
        instr_addr = ra;
        #1 check("rnd_instr_idle", 32'(instr), 32'(iram_m[ra]));
      end else if (sel <= 7) begin
        read_check("rnd_rd", a, dram_m[a]);
      end else begin
        int n;
        int cyc;
        n = $urandom_range(1, 4);
        send(C_RUN, 8'h00, 32'(n));
        cyc = 0;
        while (cpu_rst === 1'b0 && cyc < 100) begin
          logic [7:0]  ma;
          logic [7:0]  ia;
          logic        w;
          logic [31:0] wd;
          ma = 8'h80 | 8'($urandom_range(0, 15));
          ia = 8'h80 | 8'($urandom_range(0, 15));
          w  = 1'($urandom_range(0, 1));
          wd = $urandom;
          mem_wr     = w;
          mem_addr   = ma;
          cpu_wdata  = wd;
          instr_addr = ia;
          #1;
          check("rnd_cpu_rdata", cpu_rdata, dram_m[ma]);
          check("rnd_instr_run", 32'(instr), 32'(iram_m[ia]));
          if (w) dram_m[ma] = wd;
          cyc++;
          @(negedge clk);
        end
        mem_wr = 1'b0;
        check("rnd_run_len", 32'(cyc), 32'(n));
        check("rnd_run_done", 32'(run_done), 32'd1);
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the accumulator processor's two memory interfaces.
- Serves the instruction fetch port (instr_addr -> instr) and the data port (mem_addr/mem_wr/write data -> read data) from two on-chip RAMs.
- Adds a host command port for loading programs and data, reading data back, and running the processor for a bounded number of cycles.
- The processor is held in reset through cpu_rst whenever it is not running.

Parameters:
- IADDR_W, 8, instruction address width (2^IADDR_W words).
- INSTR_W, 12, instruction word width.
- DADDR_W, 8, data address width (2^DADDR_W words).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- instr_addr  in  IADDR_W  processor fetch address.
- instr  out  INSTR_W  instruction at instr_addr.
- mem_wr  in  1  processor data write enable.
- mem_addr  in  DADDR_W  processor data address.
- cpu_wdata  in  DATA_W  processor write data (its accumulator).
- cpu_rdata  out  DATA_W  data word returned to processor.
- cpu_rst  out  1  registered reset to processor; 1 = held.
- host_valid  in  1  host command valid.
- host_ready  out  1  responder accepts a command this cycle.
- host_cmd  in  2  00 WR_INSTR, 01 WR_DATA, 10 RD_DATA, 11 RUN.
- host_addr  in  8  target address (low bits used per RAM).
- host_wdata  in  DATA_W  write data, or cycle count for RUN.
- host_rvalid  out  1  one-cycle pulse, host_rdata valid.
- host_rdata  out  DATA_W  read-back data.
- run_done  out  1  one-cycle pulse when a RUN finishes.

Behaviour:
- Reset (async): state IDLE, cpu_rst=1, host_rvalid=0, host_rdata=0, run_done=0, run counter=0. RAM contents are not cleared. Reset during RUN re-asserts cpu_rst immediately and preserves RAM contents.
- States:
  - IDLE: host_ready=1, cpu_rst=1.
  - RDRESP: host_ready=0.
  - RUN: host_ready=0, cpu_rst=0.
- A command is accepted on a rising edge where host_valid & host_ready.
- WR_INSTR: iram[host_addr] <= host_wdata[INSTR_W-1:0] at the accept edge; upper bits are ignored. Stay in IDLE.
- WR_DATA: dram[host_addr] <= host_wdata at the accept edge. Stay in IDLE.
- RD_DATA: go to RDRESP. In the next cycle host_rvalid=1 and host_rdata holds dram[address sampled at accept]. Then return to IDLE. Throughput is one read per 2 cycles. host_rdata holds its value until the next read.
- RUN with host_wdata=0: no-op, stay in IDLE, cpu_rst stays 1, no run_done.
- RUN with host_wdata=N>0:
  - Load the counter with N and enter RUN. cpu_rst is low for exactly N consecutive cycles, starting the cycle after accept.
  - The counter decrements each RUN cycle. On the edge where counter==1, go to IDLE, set cpu_rst=1, and pulse run_done for the next cycle.
- Instruction read: instr = iram[instr_addr], combinational (asynchronous read) and valid in every state.
- Data read: cpu_rdata = dram[rd_addr], combinational. rd_addr = mem_addr in RUN, else the latched host read address. cpu_rdata is don't-care outside RUN.
- CPU write: dram[mem_addr] <= cpu_wdata at the clock edge when mem_wr & state==RUN. mem_wr is ignored in IDLE/RDRESP.
- Read-during-write, same address: combinational read returns the old value in that cycle and the new value next cycle.
- host_valid while host_ready=0 is ignored. The host must hold the command; nothing is queued.
- Address widths match the RAM depth, so there is no wrap or out-of-range case. Counter width is DATA_W, unsigned.

Decomposition:
- Package mem_responder_pkg holds:
  - Command encodings CMD_WR_INSTR, CMD_WR_DATA, CMD_RD_DATA, CMD_RUN.
  - State enum IDLE/RDRESP/RUN.
- Sub-module ram_1w1r: parameterised width/depth, one synchronous write port, one asynchronous read port. Instantiated twice (instruction RAM and data RAM).
- The FSM, run counter and port muxing live in the top level.

Test Plan:
- Reset mid-RUN with N=100 at cycle 20 -> cpu_rst=1 asynchronously; state IDLE; host_ready=1; previously written dram values unchanged on RD_DATA.
- WR_INSTR addr 0x05, wdata 0xFFFF_F9A3; then drive instr_addr=0x05 -> instr=0x9A3 the same cycle.
- WR_DATA addr 0x10, wdata 0xDEAD_BEEF; RD_DATA addr 0x10 -> host_rvalid one cycle later, host_rdata=0xDEADBEEF; host_ready=0 in that cycle; back-to-back valid sees 2-cycle spacing.
- RUN N=5 -> cpu_rst low exactly 5 cycles; run_done pulses once in the cycle cpu_rst returns high; host_ready=0 throughout. RUN N=0 -> no cpu_rst change, no run_done.
- During RUN drive mem_wr=1, mem_addr=0x20, cpu_wdata=-7 -> next cycle cpu_rdata@0x20 = 0xFFFFFFF9; after run, RD_DATA 0x20 returns 0xFFFFFFF9. The same mem_wr in IDLE leaves dram unchanged.
- Read-during-write to 0x30 (old 1, new 2) -> cpu_rdata=1 in the write cycle, 2 in the following cycle.
